// File: rtl/bram_acq_sequencer_pkg.sv
// Shared types and constants for the BRAM acquisition sequencer.
// State codes are visible to software through the status register.
package bram_acq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_PRE       = 3'd1,
    ST_WAIT_TRIG = 3'd2,
    ST_POST      = 3'd3,
    ST_DONE      = 3'd4
  } acq_state_e;

  localparam int ADDR_SHIFT = 2;
  localparam int WEN_WIDTH  = 4;

endpackage

// File: rtl/bram_acq_sequencer_decimator.sv
// Decimation counter: one tick every decim+1 enabled cycles.
// The counter restarts from zero whenever the sequencer is not capturing.
module acq_decimator #(
  parameter int DECIM_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   en,
  input  logic [DECIM_WIDTH-1:0] decim,
  output logic                   tick
);

  logic [DECIM_WIDTH-1:0] dec_cnt;

  assign tick = en && (dec_cnt == decim);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      dec_cnt <= '0;
    end else if (!en || tick) begin
      dec_cnt <= '0;
    end else begin
      dec_cnt <= dec_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/bram_acq_sequencer.sv
// Acquisition sequencer: pre-trigger fill, circular wait-for-trigger, post-trigger fill.
// Drives the BRAM byte address / write enables and records where the trigger sample landed.
module bram_acq_sequencer
  import bram_acq_pkg::*;
#(
  parameter int COUNT_WIDTH = 13,
  parameter int DECIM_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   arm,
  input  logic                   abort,
  input  logic                   trig,
  input  logic [COUNT_WIDTH-1:0] count_max,
  input  logic [COUNT_WIDTH-1:0] pretrig_count,
  input  logic [DECIM_WIDTH-1:0] decim,
  output logic [31:0]            address,
  output logic [WEN_WIDTH-1:0]   wen,
  output logic                   busy,
  output logic                   done,
  output logic [31:0]            trig_addr,
  output logic [2:0]             state
);

  localparam logic [COUNT_WIDTH-1:0] CNT_ONE  = COUNT_WIDTH'(1);
  localparam logic [COUNT_WIDTH:0]   POST_ONE = (COUNT_WIDTH + 1)'(1);

  acq_state_e st_q, st_d;
  logic                   arm_reg, trig_reg, arm_rise, trig_rise;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic [COUNT_WIDTH-1:0] cm_q, pc_q;
  logic [DECIM_WIDTH-1:0] decim_q;
  logic [COUNT_WIDTH:0]   post_cnt_q, post_cnt_d, post_total;
  logic                   trig_pend_q, trig_pend_d;
  logic [31:0]            trig_addr_d;
  logic                   wr, tick, load_cfg;

  function automatic logic [COUNT_WIDTH-1:0] clamp_pc(input logic [COUNT_WIDTH-1:0] pc,
                                                     input logic [COUNT_WIDTH-1:0] cm);
    return (pc > cm) ? cm : pc;
  endfunction

  function automatic logic [31:0] byte_addr(input logic [COUNT_WIDTH-1:0] c);
    return 32'(c) << ADDR_SHIFT;
  endfunction

  assign arm_rise   = arm & ~arm_reg;
  assign trig_rise  = trig & ~trig_reg;
  assign busy       = (st_q == ST_PRE) || (st_q == ST_WAIT_TRIG) || (st_q == ST_POST);
  assign done       = (st_q == ST_DONE);
  assign state      = st_q;
  assign post_total = ({1'b0, cm_q} + POST_ONE) - {1'b0, pc_q};

  acq_decimator #(.DECIM_WIDTH(DECIM_WIDTH)) u_decim (
    .clk    (clk),
    .resetn (resetn),
    .en     (busy),
    .decim  (decim_q),
    .tick   (tick)
  );

  always_comb begin
    st_d        = st_q;
    count_d     = count_q;
    post_cnt_d  = post_cnt_q;
    trig_pend_d = trig_pend_q;
    trig_addr_d = trig_addr;
    wr          = 1'b0;
    load_cfg    = 1'b0;
    if (abort) begin
      st_d = ST_IDLE;
    end else begin
      case (st_q)
        ST_IDLE, ST_DONE: begin
          if (arm_rise) begin
            load_cfg    = 1'b1;
            count_d     = '0;
            trig_pend_d = 1'b0;
            st_d = (clamp_pc(pretrig_count, count_max) == '0) ? ST_WAIT_TRIG : ST_PRE;
          end
        end
        ST_PRE: begin
          if (tick) begin
            wr = 1'b1;
            if (count_q == pc_q - CNT_ONE) st_d = ST_WAIT_TRIG;
          end
        end
        ST_WAIT_TRIG: begin
          if (trig_rise) trig_pend_d = 1'b1;
          if (tick) begin
            wr = 1'b1;
            if (trig_pend_q || trig_rise) begin
              trig_addr_d = byte_addr(count_q);
              post_cnt_d  = POST_ONE;
              st_d        = ST_POST;
            end
          end
        end
        ST_POST: begin
          // Completion is checked before the tick so the closing cycle never writes.
          if (post_cnt_q == post_total) begin
            st_d = ST_DONE;
          end else if (tick) begin
            wr         = 1'b1;
            post_cnt_d = post_cnt_q + POST_ONE;
          end
        end
        default: st_d = ST_IDLE;
      endcase
    end
    if (wr) count_d = (count_q == cm_q) ? '0 : count_q + CNT_ONE;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      st_q        <= ST_IDLE;
      count_q     <= '0;
      post_cnt_q  <= '0;
      trig_pend_q <= 1'b0;
      trig_addr   <= '0;
      address     <= '0;
      wen         <= '0;
      arm_reg     <= 1'b0;
      trig_reg    <= 1'b0;
    end else begin
      st_q        <= st_d;
      count_q     <= count_d;
      post_cnt_q  <= post_cnt_d;
      trig_pend_q <= trig_pend_d;
      trig_addr   <= trig_addr_d;
      wen         <= wr ? '1 : '0;
      arm_reg     <= arm;
      trig_reg    <= trig;
      if (wr) address <= byte_addr(count_q);
    end
  end

  // Configuration is captured once per acquisition and needs no reset.
  always_ff @(posedge clk) begin
    if (load_cfg) begin
      cm_q    <= count_max;
      pc_q    <= clamp_pc(pretrig_count, count_max);
      decim_q <= decim;
    end
  end

endmodule

// File: tb/tb_bram_acq_sequencer.sv
// Scoreboard bench for bram_acq_sequencer: expected writes come from a closed-form
// per-acquisition schedule; a monitor pops and compares on every asserted wen.
module tb_bram_acq_sequencer;

  logic        clk;
  logic        resetn;
  logic        arm, abort, trig;
  logic [12:0] count_max, pretrig_count;
  logic [15:0] decim;
  logic [31:0] address, trig_addr;
  logic [3:0]  wen;
  logic        busy, done;
  logic [2:0]  state;

  typedef struct {
    int          at;
    logic [31:0] addr;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  bram_acq_sequencer dut (
    .clk           (clk),
    .resetn        (resetn),
    .arm           (arm),
    .abort         (abort),
    .trig          (trig),
    .count_max     (count_max),
    .pretrig_count (pretrig_count),
    .decim         (decim),
    .address       (address),
    .wen           (wen),
    .busy          (busy),
    .done          (done),
    .trig_addr     (trig_addr),
    .state         (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (wen !== 4'h0) begin
      if (sb.size() == 0) begin
        chk("unexpected_write", {28'h0, wen}, 32'h0);
      end else begin
        mon_e = sb.pop_front();
        chk("wen", {28'h0, wen}, 32'hF);
        chk("wr_addr", address, mon_e.addr);
        chk("wr_cycle", 32'(cyc), 32'(mon_e.at));
      end
    end
  end

  // One acquisition. Offsets are in clock edges relative to the arm edge e0.
  // r1o/r2o: trigger pulse edges (r1o=0 none); th: trig held high up to edge e0+th-1;
  // kind: 0 normal, 1 abort+arm at e0+cut_o, 2 async reset just before edge e0+cut_o.
  task automatic acq(input int cm, input int pcin, input int d, input int r1o,
                     input int r2o, input int cut_o, input int kind, input int th);
    int e0, pc, npost, w, r, kt, last, dedge, cut, stop, c, n, t;
    exp_t e;
    @(negedge clk);
    count_max     = 13'(cm);
    pretrig_count = 13'(pcin);
    decim         = 16'(d);
    e0    = cyc + 1;
    pc    = (pcin < cm) ? pcin : cm;
    npost = cm + 1 - pc;
    w     = (pc == 0) ? e0 : e0 + pc * (d + 1);
    r     = (r1o > 0 && e0 + r1o > w) ? e0 + r1o : e0 + r2o;
    kt    = (r - e0 + d) / (d + 1) - 1;
    if (kt < pc) kt = pc;
    last  = kt + npost - 1;
    dedge = e0 + (last + 1) * (d + 1) + 1;
    cut   = (kind != 0) ? e0 + cut_o : dedge + 1000;
    for (int k = 0; k <= last; k++) begin
      t = e0 + (k + 1) * (d + 1);
      if (t < cut) begin
        e.at   = t;
        e.addr = 32'((k % (cm + 1)) * 4);
        sb.push_back(e);
      end
    end
    stop = (kind != 0) ? cut + 4 : dedge;
    while (1) begin
      c = cyc;
      if (kind == 2 && c == cut) resetn = 1'b1;
      if (c == e0) begin
        chk("busy_after_arm", {31'h0, busy}, 32'h1);
        chk("state_after_arm", {29'h0, state}, (pc == 0) ? 32'd2 : 32'd1);
      end
      if (kind == 0 && c == dedge - 1) chk("done_early", {31'h0, done}, 32'h0);
      if (kind == 0 && c == dedge) begin
        chk("done", {31'h0, done}, 32'h1);
        chk("done_state", {29'h0, state}, 32'd4);
        chk("done_busy", {31'h0, busy}, 32'h0);
        chk("done_wen", {28'h0, wen}, 32'h0);
        chk("trig_addr", trig_addr, 32'((kt % (cm + 1)) * 4));
      end
      if (kind == 1 && c == cut) begin
        chk("abort_state", {29'h0, state}, 32'd0);
        chk("abort_busy", {31'h0, busy}, 32'h0);
        chk("abort_done", {31'h0, done}, 32'h0);
        chk("abort_wen", {28'h0, wen}, 32'h0);
      end
      if (c >= stop) break;
      n     = c + 1;
      arm   = (n - e0 < 2) || (kind == 1 && n == cut);
      abort = (kind == 1 && n == cut);
      trig  = (n < e0 + th) || (r1o > 0 && n == e0 + r1o) || (n == e0 + r2o);
      if (kind == 2 && n == cut) begin
        #2 resetn = 1'b0;
        #1;
        chk("rst_address", address, 32'h0);
        chk("rst_wen", {28'h0, wen}, 32'h0);
        chk("rst_busy", {31'h0, busy}, 32'h0);
        chk("rst_done", {31'h0, done}, 32'h0);
        chk("rst_trig_addr", trig_addr, 32'h0);
        chk("rst_state", {29'h0, state}, 32'd0);
      end
      @(negedge clk);
    end
    arm   = 1'b0;
    abort = 1'b0;
    trig  = 1'b0;
  endtask

  initial begin
    int cm, pcin, d, r1o, r2o;
    resetn = 1'b0;
    arm = 1'b0; abort = 1'b0; trig = 1'b0;
    count_max = '0; pretrig_count = '0; decim = '0;
    @(posedge clk);
    #1;
    chk("init_address", address, 32'h0);
    chk("init_wen", {28'h0, wen}, 32'h0);
    chk("init_busy", {31'h0, busy}, 32'h0);
    chk("init_done", {31'h0, done}, 32'h0);
    chk("init_trig_addr", trig_addr, 32'h0);
    chk("init_state", {29'h0, state}, 32'd0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;

    acq(7, 2, 0, 10, 200, 0, 0, 0);
    @(negedge clk) trig = 1'b1;
    repeat (2) @(negedge clk);
    acq(3, 0, 3, 0, 18, 0, 0, 14);
    acq(5, 1, 4, 13, 200, 0, 0, 0);
    acq(7, 5, 0, 2, 12, 0, 0, 0);
    acq(7, 2, 0, 5, 200, 7, 1, 0);
    acq(7, 2, 0, 5, 200, 8, 2, 0);
    acq(7, 9, 0, 3, 30, 0, 0, 0);

    for (int i = 0; i < 20; i++) begin
      cm   = int'($urandom_range(1, 15));
      pcin = int'($urandom_range(0, cm + 3));
      d    = int'($urandom_range(0, 3));
      r1o  = int'($urandom_range(1, (cm + 2) * (d + 1) - 1));
      r2o  = (cm + 2) * (d + 1) + int'($urandom_range(1, 20));
      acq(cm, pcin, d, r1o, r2o, 0, 0, 0);
    end

    repeat (3) @(negedge clk);
    chk("sb_empty", 32'(sb.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
